// File: rtl/cam_access_ctrl_pkg.sv
// Shared constants and types for the CAM access controller and its helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cam_ctrl_pkg;

   localparam int KEY_W  = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);

   // Free entries hold this key, so a requester may never insert it.
   localparam logic [KEY_W-1:0] EMPTY_KEY = '0;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_LOOK,
      S_CHK,
      S_WR,
      S_RESP
   } state_t;

   // ST_MISS means DUP for an insert and NOTFOUND for a delete.
   typedef enum logic [1:0] {
      ST_OK     = 2'd0,
      ST_MISS   = 2'd1,
      ST_FULL   = 2'd2,
      ST_BADKEY = 2'd3
   } status_t;

   typedef enum logic {
      OP_INS = 1'b0,
      OP_DEL = 1'b1
   } op_t;

   typedef enum logic {
      RR_UPD  = 1'b0,
      RR_SRCH = 1'b1
   } rr_t;

   typedef struct packed {
      logic             is_srch;
      op_t              op;
      logic [KEY_W-1:0] key;
   } req_t;

   function automatic logic is_empty_key(input logic [KEY_W-1:0] k);
      return k == EMPTY_KEY;
   endfunction

endpackage

// File: rtl/cam_access_ctrl_if.sv
// Requester-side handshake bundle: update and search channels plus status.
// Latency: none (wiring only).
// Backpressure: req is held by the master until the matching one-cycle ack.
interface cam_access_ctrl_if;
   import cam_ctrl_pkg::*;

   logic              upd_req;
   logic              upd_op;
   logic [KEY_W-1:0]  upd_key;
   logic              upd_ack;
   status_t           upd_status;
   logic [ADDR_W-1:0] upd_addr;

   logic              srch_req;
   logic [KEY_W-1:0]  srch_key;
   logic              srch_ack;
   logic              srch_hit;
   logic [ADDR_W-1:0] srch_addr;

   logic              ready;
   logic              full;

   modport master (
      output upd_req, upd_op, upd_key, srch_req, srch_key,
      input  upd_ack, upd_status, upd_addr, srch_ack, srch_hit, srch_addr,
      input  ready, full
   );

   modport slave (
      input  upd_req, upd_op, upd_key, srch_req, srch_key,
      output upd_ack, upd_status, upd_addr, srch_ack, srch_hit, srch_addr,
      output ready, full
   );

endinterface

// File: rtl/cam_access_ctrl_free_alloc.sv
// Lowest-index free-slot finder over the valid bitmap.
// Latency: combinational.
// Backpressure: none; any_free low means the table is full.
module cam_free_alloc
   import cam_ctrl_pkg::*;
(
   input  logic [DEPTH-1:0]  valid,
   output logic [ADDR_W-1:0] alloc_addr,
   output logic              any_free
);

   // Scan from the top so the lowest clear bit is the last one written.
   always_comb begin
      alloc_addr = '0;
      any_free   = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            alloc_addr = ADDR_W'(i);
            any_free   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_access_ctrl.sv
// Initialises the CAM, arbitrates update/search requesters round-robin, allocates slots.
// Latency grant->ack: search 3, update with write 4, rejected update 3, bad key 1.
// Backpressure: requests are held until ack; nothing is granted before ready.
module cam_access_ctrl
   import cam_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   cam_access_ctrl_if.slave  bus,
   output logic              cam_wen,
   output logic              cam_ren,
   output logic [KEY_W-1:0]  cam_din,
   output logic [ADDR_W-1:0] cam_addr,
   input  logic [ADDR_W-1:0] cam_dout,
   input  logic              cam_hit
);

   localparam int CNT_W = ADDR_W + 1;

   state_t            state;
   logic [CNT_W-1:0]  init_cnt;
   logic [DEPTH-1:0]  valid;
   rr_t               rr_last;
   req_t              cur;
   logic [ADDR_W-1:0] tgt;

   logic [ADDR_W-1:0] alloc_addr;
   logic              any_free;
   logic              qhit;
   logic              grant_upd;
   logic              grant_srch;

   cam_free_alloc u_free_alloc (
      .valid      (valid),
      .alloc_addr (alloc_addr),
      .any_free   (any_free)
   );

   assign bus.full = &valid;

   // A raw CAM hit on a free entry is only a stale EMPTY_KEY match.
   assign qhit = cam_hit & valid[cam_dout];

   always_comb begin
      grant_upd  = 1'b0;
      grant_srch = 1'b0;
      if (bus.upd_req && bus.srch_req) begin
         grant_upd  = (rr_last == RR_SRCH);
         grant_srch = (rr_last == RR_UPD);
      end else begin
         grant_upd  = bus.upd_req;
         grant_srch = bus.srch_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_INIT;
         init_cnt       <= '0;
         valid          <= '0;
         rr_last        <= RR_SRCH;
         cur            <= '0;
         tgt            <= '0;
         cam_wen        <= 1'b0;
         cam_ren        <= 1'b0;
         cam_din        <= '0;
         cam_addr       <= '0;
         bus.ready      <= 1'b0;
         bus.upd_ack    <= 1'b0;
         bus.upd_status <= ST_OK;
         bus.upd_addr   <= '0;
         bus.srch_ack   <= 1'b0;
         bus.srch_hit   <= 1'b0;
         bus.srch_addr  <= '0;
      end else begin
         case (state)
            S_INIT: begin
               // The counter's top bit marks that all DEPTH entries were written.
               if (init_cnt[ADDR_W]) begin
                  cam_wen   <= 1'b0;
                  bus.ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cam_wen  <= 1'b1;
                  cam_din  <= EMPTY_KEY;
                  cam_addr <= init_cnt[ADDR_W-1:0];
                  init_cnt <= init_cnt + CNT_W'(1);
               end
            end

            S_IDLE: begin
               if (grant_upd) begin
                  rr_last     <= RR_UPD;
                  cur.is_srch <= 1'b0;
                  cur.op      <= op_t'(bus.upd_op);
                  cur.key     <= bus.upd_key;
                  if (is_empty_key(bus.upd_key)) begin
                     bus.upd_ack    <= 1'b1;
                     bus.upd_status <= ST_BADKEY;
                     state          <= S_RESP;
                  end else begin
                     cam_ren <= 1'b1;
                     cam_din <= bus.upd_key;
                     state   <= S_LOOK;
                  end
               end else if (grant_srch) begin
                  rr_last     <= RR_SRCH;
                  cur.is_srch <= 1'b1;
                  cur.op      <= OP_INS;
                  cur.key     <= bus.srch_key;
                  cam_ren     <= 1'b1;
                  cam_din     <= bus.srch_key;
                  state       <= S_LOOK;
               end
            end

            S_LOOK: begin
               cam_ren <= 1'b0;
               state   <= S_CHK;
            end

            S_CHK: begin
               if (cur.is_srch) begin
                  bus.srch_ack  <= 1'b1;
                  bus.srch_hit  <= qhit;
                  bus.srch_addr <= qhit ? cam_dout : '0;
                  state         <= S_RESP;
               end else if (cur.op == OP_INS) begin
                  if (qhit) begin
                     bus.upd_ack    <= 1'b1;
                     bus.upd_status <= ST_MISS;
                     state          <= S_RESP;
                  end else if (!any_free) begin
                     bus.upd_ack    <= 1'b1;
                     bus.upd_status <= ST_FULL;
                     state          <= S_RESP;
                  end else begin
                     tgt      <= alloc_addr;
                     cam_wen  <= 1'b1;
                     cam_addr <= alloc_addr;
                     cam_din  <= cur.key;
                     state    <= S_WR;
                  end
               end else begin
                  if (qhit) begin
                     tgt      <= cam_dout;
                     cam_wen  <= 1'b1;
                     cam_addr <= cam_dout;
                     cam_din  <= EMPTY_KEY;
                     state    <= S_WR;
                  end else begin
                     bus.upd_ack    <= 1'b1;
                     bus.upd_status <= ST_MISS;
                     state          <= S_RESP;
                  end
               end
            end

            S_WR: begin
               cam_wen        <= 1'b0;
               valid[tgt]     <= (cur.op == OP_INS);
               bus.upd_ack    <= 1'b1;
               bus.upd_status <= ST_OK;
               bus.upd_addr   <= tgt;
               state          <= S_RESP;
            end

            S_RESP: begin
               bus.upd_ack    <= 1'b0;
               bus.upd_status <= ST_OK;
               bus.upd_addr   <= '0;
               bus.srch_ack   <= 1'b0;
               bus.srch_hit   <= 1'b0;
               bus.srch_addr  <= '0;
               state          <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Scoreboard bench for cam_access_ctrl with a behavioural registered CAM.
// Stimulus pushes expected responses; a negedge monitor pops and compares on each ack.
module tb_cam_access_ctrl;
   import cam_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cam_access_ctrl_if bus();

   logic       cam_wen, cam_ren;
   logic [7:0] cam_din;
   logic [3:0] cam_addr;
   logic [3:0] cam_dout = 4'd0;
   logic       cam_hit  = 1'b0;

   cam_access_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .cam_wen  (cam_wen),
      .cam_ren  (cam_ren),
      .cam_din  (cam_din),
      .cam_addr (cam_addr),
      .cam_dout (cam_dout),
      .cam_hit  (cam_hit)
   );

   // Registered CAM: lowest matching index wins; starts with junk contents.
   logic [7:0] mem [16] = '{default: 8'hA5};
   always @(posedge clk) begin
      if (cam_wen) mem[cam_addr] <= cam_din;
      if (cam_ren) begin
         cam_hit <= 1'b0;
         for (int i = 15; i >= 0; i--) begin
            if (mem[i] == cam_din) begin
               cam_hit  <= 1'b1;
               cam_dout <= 4'(i);
            end
         end
      end
   end

   typedef struct {
      bit is_srch;
      int status;
      int hit;
      int addr;
      int issue;
      int lat;
   } exp_t;

   exp_t  q[$];
   string tq[$];
   exp_t  me;
   string mt;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int ack_cnt = 0;
   int wen_cnt = 0;
   int w0, a0;
   logic [3:0] last_wa = 4'd0;
   logic [7:0] last_wd = 8'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (cam_wen && bus.ready) begin
            wen_cnt++;
            last_wa = cam_addr;
            last_wd = cam_din;
         end
         if (bus.upd_ack || bus.srch_ack) begin
            ack_cnt++;
            chk("ack_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               me = q.pop_front();
               mt = tq.pop_front();
               chk({mt, "_kind"}, int'(bus.srch_ack), int'(me.is_srch));
               chk({mt, "_single_ack"}, int'(bus.upd_ack & bus.srch_ack), 0);
               if (me.is_srch) begin
                  chk({mt, "_hit"}, int'(bus.srch_hit), me.hit);
                  chk({mt, "_addr"}, int'(bus.srch_addr), me.addr);
               end else begin
                  chk({mt, "_status"}, int'(bus.upd_status), me.status);
                  chk({mt, "_addr"}, int'(bus.upd_addr), me.addr);
               end
               if (me.lat >= 0) chk({mt, "_latency"}, cyc - me.issue, me.lat);
            end
         end
      end
   end

   task automatic push(string tag, bit is_srch, int st, int hit, int addr, int lat);
      exp_t e;
      e.is_srch = is_srch;
      e.status  = st;
      e.hit     = hit;
      e.addr    = addr;
      e.issue   = cyc;
      e.lat     = lat;
      q.push_back(e);
      tq.push_back(tag);
   endtask

   // Raise a request, hold it until its ack, drop it on the edge ending the ack cycle.
   task automatic drive(bit is_srch, bit op, logic [7:0] key);
      bit got = 1'b0;
      if (is_srch) begin
         bus.srch_key = key;
         bus.srch_req = 1'b1;
      end else begin
         bus.upd_op  = op;
         bus.upd_key = key;
         bus.upd_req = 1'b1;
      end
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (is_srch ? bus.srch_ack : bus.upd_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk(is_srch ? "srch_ack_seen" : "upd_ack_seen", int'(got), 1);
      @(posedge clk);
      #1;
      if (is_srch) bus.srch_req = 1'b0;
      else         bus.upd_req  = 1'b0;
   endtask

   task automatic upd(string tag, bit op, logic [7:0] key, int st, int addr, int lat);
      push(tag, 1'b0, st, 0, addr, lat);
      drive(1'b0, op, key);
   endtask

   task automatic srch(string tag, logic [7:0] key, int hit, int addr, int lat);
      push(tag, 1'b1, 0, hit, addr, lat);
      drive(1'b1, 1'b0, key);
   endtask

   task automatic check_init();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (cam_wen) seen = 1'b1;
      end
      chk("init_start", int'(seen), 1);
      for (int a = 0; a < 16; a++) begin
         if (a > 0) @(negedge clk);
         chk($sformatf("init_wr%0d", a), int'({cam_wen, cam_ren, bus.ready, cam_addr, cam_din}),
             int'({3'b100, 4'(a), 8'h00}));
      end
      @(negedge clk);
      chk("init_ready", int'({bus.ready, cam_wen, bus.full}), int'(3'b100));
   endtask

   function automatic int all_outs();
      return int'({cam_wen, cam_ren, cam_din, cam_addr, bus.ready, bus.full, bus.upd_ack,
                   bus.upd_status, bus.upd_addr, bus.srch_ack, bus.srch_hit, bus.srch_addr});
   endfunction

   initial begin
      bus.upd_req  = 1'b0;
      bus.upd_op   = 1'b0;
      bus.upd_key  = 8'h00;
      bus.srch_req = 1'b0;
      bus.srch_key = 8'h00;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // A search raised during initialisation must wait and then complete.
      push("early_srch33", 1'b1, 0, 0, 0, -1);
      fork
         drive(1'b1, 1'b0, 8'h33);
         check_init();
      join

      upd("ins50", 1'b0, 8'd50, ST_OK, 0, 4);
      upd("ins2", 1'b0, 8'd2, ST_OK, 1, 4);
      srch("srch50", 8'd50, 1, 0, 3);
      w0 = wen_cnt;
      upd("dup2", 1'b0, 8'd2, ST_MISS, 0, 3);
      chk("dup_no_write", wen_cnt - w0, 0);
      srch("srch20", 8'd20, 0, 0, 3);
      w0 = wen_cnt;
      upd("del50", 1'b1, 8'd50, ST_OK, 0, 4);
      chk("del_write_cnt", wen_cnt - w0, 1);
      chk("del_write_addr_din", int'({last_wa, last_wd}), 0);
      srch("srch50_gone", 8'd50, 0, 0, 3);
      upd("ins7_reuse", 1'b0, 8'd7, ST_OK, 0, 4);
      upd("del99_nf", 1'b1, 8'd99, ST_MISS, 0, 3);

      // Slots 0/1 hold 7 and 2, so those keys are duplicates; the rest fill 2..15.
      for (int k = 1; k <= 16; k++) begin
         if (k == 2 || k == 7)
            upd($sformatf("fill%0d", k), 1'b0, 8'(k), ST_MISS, 0, 3);
         else
            upd($sformatf("fill%0d", k), 1'b0, 8'(k), ST_OK, (k == 1) ? 2 : ((k < 7) ? k : k - 1), 4);
         if (k == 15) chk("not_full_yet", int'(bus.full), 0);
      end
      chk("full_set", int'(bus.full), 1);
      upd("ins99_full", 1'b0, 8'd99, ST_FULL, 0, 3);
      w0 = wen_cnt;
      upd("badkey", 1'b0, 8'h00, ST_BADKEY, 0, 1);
      chk("badkey_no_write", wen_cnt - w0, 0);
      srch("srch16", 8'd16, 1, 15, 3);
      srch("srch2", 8'd2, 1, 1, 3);

      // Both requesters held: grants must alternate update, search, update, search.
      push("arb_u1_del16", 1'b0, ST_OK, 0, 15, -1);
      push("arb_s1_srch16", 1'b1, 0, 0, 0, -1);
      push("arb_u2_ins55", 1'b0, ST_OK, 0, 15, -1);
      push("arb_s2_srch55", 1'b1, 0, 1, 15, -1);
      fork
         begin
            drive(1'b0, 1'b1, 8'd16);
            drive(1'b0, 1'b0, 8'h55);
         end
         begin
            drive(1'b1, 1'b0, 8'd16);
            drive(1'b1, 1'b0, 8'h55);
         end
      join
      chk("full_after_arb", int'(bus.full), 1);

      // Reset during LOOK abandons the search and reruns initialisation.
      bus.srch_key = 8'h55;
      bus.srch_req = 1'b1;
      @(posedge clk);
      #1;
      chk("look_ren", int'(cam_ren), 1);
      a0 = ack_cnt;
      rst = 1'b1;
      bus.srch_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("midop_reset_outputs", all_outs(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_init();
      chk("no_ack_after_reset", ack_cnt - a0, 0);
      @(posedge clk);
      #1;
      srch("srch55_after_reinit", 8'h55, 0, 0, 3);
      upd("ins9_after_reinit", 1'b0, 8'd9, ST_OK, 0, 4);
      chk("queue_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
